// File: rtl/redundancy_pair_scanner.sv
// redundancy_pair_scanner
//
// Loads one filter's flattened weights into a small buffer, then walks every
// ordered index pair (idx1 < idx2) once, presenting each pair whose weights
// are equal and nonzero on a valid/ready output. Each presented pair carries
// the layer geometry captured at configuration time.
//
// State table:
//   state  | meaning
//   IDLE   | waiting for a cfg handshake; cfg_ready high
//   LOAD   | accepting cfg_len (clamped to MAX_K) weights on the w_* stream
//   SCAN   | evaluating one candidate (i,j) per cycle, stalling on backpressure
//   DONE   | one-cycle done pulse, then back to IDLE
//
// Ports:
//   clk, reset              clock, synchronous active-high reset
//   cfg_valid/cfg_ready     start handshake; cfg_ow/fw/st/len captured on it
//   w_valid/w_ready/w_data  weight stream, accepted only in LOAD
//   pair_valid/pair_ready   matching-pair handshake; idx1/idx2 hold the pair
//   ow, fw, st              geometry held from one cfg capture to the next
//   busy                    state is not IDLE
//   done                    one-cycle pulse when the scan completes

module redundancy_pair_scanner #(
    parameter int WORD_WIDTH = 8,
    parameter int MAX_K      = 16
) (
    input  logic                  clk,
    input  logic                  reset,

    input  logic                  cfg_valid,
    output logic                  cfg_ready,
    input  logic [WORD_WIDTH-1:0] cfg_ow,
    input  logic [WORD_WIDTH-1:0] cfg_fw,
    input  logic [WORD_WIDTH-1:0] cfg_st,
    input  logic [WORD_WIDTH-1:0] cfg_len,

    input  logic                  w_valid,
    input  logic [WORD_WIDTH-1:0] w_data,
    output logic                  w_ready,

    output logic                  pair_valid,
    input  logic                  pair_ready,
    output logic [WORD_WIDTH-1:0] idx1,
    output logic [WORD_WIDTH-1:0] idx2,

    output logic [WORD_WIDTH-1:0] ow,
    output logic [WORD_WIDTH-1:0] fw,
    output logic [WORD_WIDTH-1:0] st,

    output logic                  busy,
    output logic                  done
);

    // Length needs one extra bit: MAX_K may equal 2^WORD_WIDTH.
    localparam int LW = WORD_WIDTH + 1;
    localparam int AW = (MAX_K > 1) ? $clog2(MAX_K) : 1;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_LOAD = 2'd1;
    localparam logic [1:0] S_SCAN = 2'd2;
    localparam logic [1:0] S_DONE = 2'd3;

    localparam logic [LW-1:0]         L_ONE  = LW'(1);
    localparam logic [LW-1:0]         L_TWO  = LW'(2);
    localparam logic [LW-1:0]         L_MAXK = LW'(MAX_K);
    localparam logic [WORD_WIDTH-1:0] W_ONE  = WORD_WIDTH'(1);
    localparam logic [WORD_WIDTH-1:0] W_TWO  = WORD_WIDTH'(2);

    logic [1:0]            state;
    logic [LW-1:0]         len;
    logic [WORD_WIDTH-1:0] cnt;
    logic [WORD_WIDTH-1:0] i_q;
    logic [WORD_WIDTH-1:0] j_q;
    logic [WORD_WIDTH-1:0] ow_q;
    logic [WORD_WIDTH-1:0] fw_q;
    logic [WORD_WIDTH-1:0] st_q;

    logic [WORD_WIDTH-1:0] wbuf [MAX_K];

    logic [LW-1:0]         cfg_len_ext;
    logic [LW-1:0]         len_clamped;
    logic                  w_fire;
    logic                  load_last;
    logic [WORD_WIDTH-1:0] wi;
    logic [WORD_WIDTH-1:0] wj;
    logic                  match;
    logic                  advance;
    logic                  row_end;
    logic                  last_cand;

    // ------------------------------------------------------------------
    // Combinational decode
    // ------------------------------------------------------------------
    assign cfg_len_ext = {1'b0, cfg_len};
    assign len_clamped = (cfg_len_ext > L_MAXK) ? L_MAXK : cfg_len_ext;

    assign w_fire    = (state == S_LOAD) && w_valid;
    assign load_last = ({1'b0, cnt} == (len - L_ONE));

    // Both reads come straight from registered i/j, so pair_valid never
    // depends on pair_ready.
    assign wi = wbuf[i_q[AW-1:0]];
    assign wj = wbuf[j_q[AW-1:0]];

    assign match   = (state == S_SCAN) && (wi == wj) && (wi != '0);
    assign advance = (state == S_SCAN) && (!match || pair_ready);

    assign row_end   = ({1'b0, j_q} == (len - L_ONE));
    assign last_cand = row_end && ({1'b0, i_q} == (len - L_TWO));

    // ------------------------------------------------------------------
    // Control state, counters and geometry
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= S_IDLE;
            len   <= '0;
            cnt   <= '0;
            i_q   <= '0;
            j_q   <= '0;
            ow_q  <= '0;
            fw_q  <= '0;
            st_q  <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (cfg_valid) begin
                        ow_q  <= cfg_ow;
                        fw_q  <= cfg_fw;
                        st_q  <= cfg_st;
                        len   <= len_clamped;
                        cnt   <= '0;
                        state <= (len_clamped == '0) ? S_DONE : S_LOAD;
                    end
                end

                S_LOAD: begin
                    if (w_valid) begin
                        cnt <= cnt + W_ONE;
                        if (load_last) begin
                            i_q   <= '0;
                            j_q   <= W_ONE;
                            state <= (len == L_ONE) ? S_DONE : S_SCAN;
                        end
                    end
                end

                S_SCAN: begin
                    // Stalled match (pair_valid && !pair_ready) keeps i/j frozen.
                    if (advance) begin
                        if (last_cand) begin
                            state <= S_DONE;
                        end else if (row_end) begin
                            i_q <= i_q + W_ONE;
                            j_q <= i_q + W_TWO;
                        end else begin
                            j_q <= j_q + W_ONE;
                        end
                    end
                end

                S_DONE: begin
                    cnt   <= '0;
                    i_q   <= '0;
                    j_q   <= '0;
                    state <= S_IDLE;
                end

                default: state <= S_IDLE;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Weight buffer (contents are don't-care outside LOAD/SCAN, so no reset)
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!reset && w_fire) begin
            wbuf[cnt[AW-1:0]] <= w_data;
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign cfg_ready  = (state == S_IDLE);
    assign w_ready    = (state == S_LOAD);
    assign busy       = (state != S_IDLE);
    assign done       = (state == S_DONE);

    assign pair_valid = match;
    assign idx1       = i_q;
    assign idx2       = j_q;

    assign ow = ow_q;
    assign fw = fw_q;
    assign st = st_q;

endmodule

// File: tb/tb_redundancy_pair_scanner.sv
module tb_redundancy_pair_scanner;

    logic       clk;
    logic       reset;
    logic       cfg_valid;
    logic       cfg_ready;
    logic [7:0] cfg_ow, cfg_fw, cfg_st, cfg_len;
    logic       w_valid;
    logic [7:0] w_data;
    logic       w_ready;
    logic       pair_valid;
    logic       pair_ready;
    logic [7:0] idx1, idx2;
    logic [7:0] ow, fw, st;
    logic       busy;
    logic       done;

    int n_checks = 0;
    int n_fail   = 0;

    redundancy_pair_scanner #(.WORD_WIDTH(8), .MAX_K(16)) dut (
        .clk        (clk),
        .reset      (reset),
        .cfg_valid  (cfg_valid),
        .cfg_ready  (cfg_ready),
        .cfg_ow     (cfg_ow),
        .cfg_fw     (cfg_fw),
        .cfg_st     (cfg_st),
        .cfg_len    (cfg_len),
        .w_valid    (w_valid),
        .w_data     (w_data),
        .w_ready    (w_ready),
        .pair_valid (pair_valid),
        .pair_ready (pair_ready),
        .idx1       (idx1),
        .idx2       (idx2),
        .ow         (ow),
        .fw         (fw),
        .st         (st),
        .busy       (busy),
        .done       (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [7:0]        cfg_len;
        logic [7:0]        ow;
        logic [7:0]        fw;
        logic [7:0]        st;
        logic [15:0][7:0]  w;          // w[k] is the k-th weight streamed
        logic              all_pairs;  // expect every (i<j) of a 16-entry buffer
        logic [3:0][15:0]  pairs;      // {idx1, idx2}, pairs[0] first
        logic [7:0]        n_pairs;
        logic [7:0]        exp_loaded;
        logic [7:0]        exp_scan;
        logic [31:0]       exp_mask;   // bit n-1 set when pair_valid on scan cycle n
        logic [7:0]        bp_cycles;  // pair_ready=0 cycles on the first pair
    } vec_t;

    localparam int NV = 10;
    vec_t vecs [NV];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
        end
    endtask

    function automatic logic [15:0][7:0] wl(input logic [7:0] a0, a1, a2, a3, a4);
        logic [15:0][7:0] r;
        r = '0;
        r[0] = a0; r[1] = a1; r[2] = a2; r[3] = a3; r[4] = a4;
        return r;
    endfunction

    function automatic logic [3:0][15:0] pl(input logic [15:0] p0, p1, p2, p3);
        logic [3:0][15:0] r;
        r[0] = p0; r[1] = p1; r[2] = p2; r[3] = p3;
        return r;
    endfunction

    function automatic vec_t mk(input logic [7:0] len, ow_v, fw_v, st_v,
                                input logic [15:0][7:0] w, input logic all_p,
                                input logic [3:0][15:0] p, input logic [7:0] np,
                                input logic [7:0] ld, input logic [7:0] sc,
                                input logic [31:0] mask, input logic [7:0] bp);
        vec_t v;
        v.cfg_len = len; v.ow = ow_v; v.fw = fw_v; v.st = st_v;
        v.w = w; v.all_pairs = all_p; v.pairs = p; v.n_pairs = np;
        v.exp_loaded = ld; v.exp_scan = sc; v.exp_mask = mask; v.bp_cycles = bp;
        return v;
    endfunction

    task automatic run_case(input vec_t v, input string tag);
        int         exp_i [$];
        int         exp_j [$];
        int         np, loaded, scan, acc, bp_left;
        logic [31:0] mask;
        logic       fin;

        if (v.all_pairs) begin
            for (int a = 0; a < 16; a++)
                for (int b = a + 1; b < 16; b++) begin
                    exp_i.push_back(a);
                    exp_j.push_back(b);
                end
        end else begin
            for (int k = 0; k < int'(v.n_pairs); k++) begin
                exp_i.push_back(int'(v.pairs[k][15:8]));
                exp_j.push_back(int'(v.pairs[k][7:0]));
            end
        end
        np = exp_i.size();

        @(negedge clk);
        chk($sformatf("%s:cfg_ready_idle", tag), 32'(cfg_ready), 32'd1);
        cfg_valid = 1'b1; cfg_ow = v.ow; cfg_fw = v.fw; cfg_st = v.st; cfg_len = v.cfg_len;
        w_valid = 1'b0; pair_ready = 1'b1;
        @(negedge clk);

        // A second cfg request with different geometry while busy must be ignored.
        cfg_valid = 1'b1; cfg_ow = ~v.ow; cfg_fw = ~v.fw; cfg_st = ~v.st; cfg_len = 8'd3;

        loaded = 0;
        for (int c = 0; c < 40; c++) begin
            if (w_ready !== 1'b1) break;
            w_valid = 1'b1;
            w_data  = v.w[loaded & 15];
            loaded++;
            @(negedge clk);
        end
        // Junk on the weight stream during SCAN must not reach the buffer.
        w_valid = 1'b1;
        w_data  = 8'h00;

        scan = 0; acc = 0; mask = '0; bp_left = int'(v.bp_cycles); fin = 1'b0;
        for (int c = 0; c < 400; c++) begin
            if (done === 1'b1) begin
                fin = 1'b1;
                break;
            end
            scan++;
            pair_ready = 1'b1;
            if (pair_valid === 1'b1) begin
                if (scan <= 32) mask[scan-1] = 1'b1;
                if (acc < np) begin
                    chk($sformatf("%s:idx1[%0d]", tag, acc), 32'(idx1), 32'(exp_i[acc]));
                    chk($sformatf("%s:idx2[%0d]", tag, acc), 32'(idx2), 32'(exp_j[acc]));
                end else begin
                    chk($sformatf("%s:extra_pair", tag), 32'(acc), 32'(np));
                end
                if (bp_left > 0) begin
                    pair_ready = 1'b0;
                    bp_left--;
                end else begin
                    acc++;
                end
            end
            @(negedge clk);
        end

        cfg_valid = 1'b0; w_valid = 1'b0; pair_ready = 1'b1;
        chk($sformatf("%s:done_seen", tag),   32'(fin),    32'd1);
        chk($sformatf("%s:loaded", tag),      32'(loaded), 32'(v.exp_loaded));
        chk($sformatf("%s:scan_cycles", tag), 32'(scan),   32'(v.exp_scan));
        chk($sformatf("%s:pairs", tag),       32'(acc),    32'(np));
        chk($sformatf("%s:pv_mask", tag),     mask,        v.exp_mask);
        chk($sformatf("%s:ow", tag),          32'(ow),     32'(v.ow));
        chk($sformatf("%s:fw", tag),          32'(fw),     32'(v.fw));
        chk($sformatf("%s:st", tag),          32'(st),     32'(v.st));
        if (fin) begin
            chk($sformatf("%s:busy_in_done", tag), 32'(busy), 32'd1);
            @(negedge clk);
            chk($sformatf("%s:done_pulse", tag),   32'(done),      32'd0);
            chk($sformatf("%s:cfg_ready_back", tag), 32'(cfg_ready), 32'd1);
            chk($sformatf("%s:busy_after", tag),   32'(busy),      32'd0);
        end
    endtask

    initial begin
        logic [15:0][7:0] wd;
        logic [15:0][7:0] w9;
        int               c;

        for (int k = 0; k < 16; k++) begin
            wd[k] = 8'(k + 1);
            w9[k] = 8'd9;
        end

        vecs[0] = mk(8'd4, 8'd20, 8'd2, 8'd1, wl(8'd5, 8'd3, 8'd5, 8'd5, 8'd0), 1'b0,
                     pl(16'h0002, 16'h0003, 16'h0203, 16'h0000), 8'd3, 8'd4, 8'd6, 32'h26, 8'd0);
        vecs[1] = mk(8'd4, 8'd20, 8'd2, 8'd1, wl(8'd5, 8'd3, 8'd5, 8'd5, 8'd0), 1'b0,
                     pl(16'h0002, 16'h0003, 16'h0203, 16'h0000), 8'd3, 8'd4, 8'd9, 32'h13E, 8'd3);
        vecs[2] = mk(8'd4, 8'd10, 8'd3, 8'd2, wl(8'd0, 8'd0, 8'd7, 8'd7, 8'd0), 1'b0,
                     pl(16'h0203, 16'h0, 16'h0, 16'h0), 8'd1, 8'd4, 8'd6, 32'h20, 8'd0);
        vecs[3] = mk(8'd0, 8'd7, 8'd1, 8'd1, wl(8'd1, 8'd1, 8'd0, 8'd0, 8'd0), 1'b0,
                     pl(16'h0, 16'h0, 16'h0, 16'h0), 8'd0, 8'd0, 8'd0, 32'h0, 8'd0);
        vecs[4] = mk(8'd1, 8'd8, 8'd1, 8'd2, wl(8'd4, 8'd4, 8'd0, 8'd0, 8'd0), 1'b0,
                     pl(16'h0, 16'h0, 16'h0, 16'h0), 8'd0, 8'd1, 8'd0, 32'h0, 8'd0);
        vecs[5] = mk(8'd200, 8'd30, 8'd4, 8'd1, wd, 1'b0,
                     pl(16'h0, 16'h0, 16'h0, 16'h0), 8'd0, 8'd16, 8'd120, 32'h0, 8'd0);
        vecs[6] = mk(8'd3, 8'd5, 8'd1, 8'd3, wl(8'd1, 8'd2, 8'd3, 8'd0, 8'd0), 1'b0,
                     pl(16'h0, 16'h0, 16'h0, 16'h0), 8'd0, 8'd3, 8'd3, 32'h0, 8'd0);
        vecs[7] = mk(8'd5, 8'd255, 8'd5, 8'd1, wl(8'hFF, 8'd1, 8'hFF, 8'd1, 8'hFF), 1'b0,
                     pl(16'h0002, 16'h0004, 16'h0103, 16'h0204), 8'd4, 8'd5, 8'd10, 32'h12A, 8'd0);
        vecs[8] = mk(8'd16, 8'd64, 8'd4, 8'd2, w9, 1'b1,
                     pl(16'h0, 16'h0, 16'h0, 16'h0), 8'd120, 8'd16, 8'd120, 32'hFFFF_FFFF, 8'd0);
        vecs[9] = mk(8'd2, 8'd12, 8'd1, 8'd1, wl(8'd6, 8'd6, 8'd0, 8'd0, 8'd0), 1'b0,
                     pl(16'h0001, 16'h0, 16'h0, 16'h0), 8'd1, 8'd2, 8'd1, 32'h1, 8'd0);

        reset = 1'b1; cfg_valid = 1'b0; cfg_ow = '0; cfg_fw = '0; cfg_st = '0; cfg_len = '0;
        w_valid = 1'b0; w_data = '0; pair_ready = 1'b1;
        repeat (3) @(negedge clk);

        chk("rst:cfg_ready",  32'(cfg_ready),  32'd1);
        chk("rst:w_ready",    32'(w_ready),    32'd0);
        chk("rst:pair_valid", 32'(pair_valid), 32'd0);
        chk("rst:idx1",       32'(idx1),       32'd0);
        chk("rst:idx2",       32'(idx2),       32'd0);
        chk("rst:geom",       {8'd0, ow, fw, st}, 32'd0);
        chk("rst:busy",       32'(busy),       32'd0);
        chk("rst:done",       32'(done),       32'd0);
        reset = 1'b0;

        for (int v = 0; v < NV; v++) run_case(vecs[v], $sformatf("vec%0d", v));

        // Reset while a match is stalled on (0,2).
        @(negedge clk);
        cfg_valid = 1'b1; cfg_ow = 8'd20; cfg_fw = 8'd2; cfg_st = 8'd1; cfg_len = 8'd4;
        @(negedge clk);
        cfg_valid = 1'b0;
        for (int k = 0; k < 4; k++) begin
            chk($sformatf("rstscan:w_ready[%0d]", k), 32'(w_ready), 32'd1);
            w_valid = 1'b1;
            w_data  = vecs[0].w[k];
            @(negedge clk);
        end
        w_valid = 1'b0;
        pair_ready = 1'b0;
        c = 0;
        while (pair_valid !== 1'b1 && c < 10) begin
            @(negedge clk);
            c++;
        end
        chk("rstscan:pv_before", 32'(pair_valid), 32'd1);
        chk("rstscan:idx2_before", 32'(idx2), 32'd2);
        reset = 1'b1;
        @(negedge clk);
        chk("rstscan:pair_valid", 32'(pair_valid), 32'd0);
        chk("rstscan:busy",       32'(busy),       32'd0);
        chk("rstscan:cfg_ready",  32'(cfg_ready),  32'd1);
        chk("rstscan:idx",        {16'd0, idx1, idx2}, 32'd0);
        chk("rstscan:geom",       {8'd0, ow, fw, st},  32'd0);
        reset = 1'b0;
        pair_ready = 1'b1;

        run_case(vecs[0], "after_reset");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/redundancy_pair_scanner.md
# redundancy_pair_scanner

Upstream feeder for the distance calculator in the redundancy controller. It loads one filter's flattened weights (fw×fw entries), scans every ordered index pair (idx1 < idx2), and emits each pair whose weights are equal and nonzero. Each emitted pair carries the layer geometry (ow, fw, st), so the downstream distance calculator can compute the output-reuse distance without extra context. Pair output uses a valid/ready handshake; weight loading is a streamed handshake.

## Interface
Parameters:
- WORD_WIDTH, 8, width of weights, indices and geometry fields
- MAX_K, 16, weight buffer depth (max flattened kernel length, ≤ 2^WORD_WIDTH)

Ports:
- clk  in  1  clock, all logic on rising edge
- reset  in  1  synchronous, active-high reset
- cfg_valid  in  1  start request
- cfg_ready  out  1  high only in IDLE
- cfg_ow, cfg_fw, cfg_st  in  WORD_WIDTH each  layer geometry, captured on cfg handshake
- cfg_len  in  WORD_WIDTH  number of weights to load; values above MAX_K are clamped to MAX_K
- w_valid  in  1  weight stream valid
- w_data  in  WORD_WIDTH  weight value
- w_ready  out  1  high only in LOAD
- pair_valid  out  1  idx1/idx2 hold a matching pair
- pair_ready  in  1  downstream accepts pair
- idx1, idx2  out  WORD_WIDTH each  pair indices (idx1 < idx2)
- ow, fw, st  out  WORD_WIDTH each  registered geometry, held from cfg capture until next cfg capture
- busy  out  1  state ≠ IDLE
- done  out  1  one-cycle pulse when scan completes

## Operation
- FSM states: IDLE, LOAD, SCAN, DONE.
- IDLE: cfg_ready=1. On cfg_valid, capture ow/fw/st and len = min(cfg_len, MAX_K).
  - len=0 → DONE.
  - Otherwise → LOAD, with load counter=0.
- LOAD: w_ready=1. Each w_valid handshake writes buf[cnt] and increments cnt.
  - On the handshake for entry len−1: if len=1 → DONE; otherwise → SCAN with i=0, j=1.
- SCAN: one candidate (i,j) is evaluated per cycle.
  - match = (buf[i]==buf[j]) && (buf[i]≠0).
  - pair_valid = match. idx1=i, idx2=j, driven directly from the i/j registers.
  - The candidate advances when !match, or when match && pair_ready.
  - Advance order: j+1. If j=len−1, then i+1 and j=i+2.
  - Advancing from (len−2, len−1) → DONE.
- DONE: done=1 for one cycle → IDLE. Buffer contents are don't-care afterwards.
- While pair_valid=1 and pair_ready=0: i, j and all outputs are frozen. No pair is dropped or duplicated.
- cfg_valid outside IDLE is ignored. w_valid outside LOAD is ignored.
- Equality is an exact WORD_WIDTH compare; no sign interpretation.

## Timing
- Reset values: state=IDLE, cfg_ready=1, w_ready=0, pair_valid=0, idx1=idx2=0, ow=fw=st=0, busy=0, done=0, counters 0.
- Reset asserted mid-LOAD or mid-SCAN returns to IDLE on the next edge with the values above. A pending pair is discarded.
- cfg handshake at cycle T: w_ready=1 from T+1.
- Last weight handshake at cycle T: first candidate (0,1) is evaluated at T+1, so pair_valid can be high at T+1.
- SCAN with no backpressure takes exactly len(len−1)/2 cycles. Each cycle of pair_ready=0 on a match adds one cycle.
- done is asserted the cycle after the last candidate advances. cfg_ready returns the following cycle.
- pair_valid is combinational from registered state (buf, i, j). It never depends combinationally on pair_ready.
- idx/geometry outputs are stable whenever pair_valid=1.

## Test plan
- Basic scan: cfg ow=20, fw=2, st=1, len=4; weights [5,3,5,5]; pair_ready=1 → pairs (0,2), (0,3), (2,3) in that order. pair_valid high on scan cycles 2, 3 and 6 (of 6). done on the cycle after scan cycle 6.
- Backpressure: same stimulus, with pair_ready=0 for 3 cycles when (0,2) is first presented → idx1=0, idx2=2 held for 4 cycles. Then (0,3) and (2,3) follow. Total scan is 9 cycles, and exactly 3 pairs are accepted.
- Zero skip: len=4, weights [0,0,7,7] → only (2,3) emitted.
- Degenerate lengths:
  - len=0: done 1 cycle after cfg, and w_ready is never high.
  - len=1: one weight loaded, then done, with no pair_valid.
  - cfg_len=200 with MAX_K=16: exactly 16 weights are accepted.
- Full buffer: len=16, all weights 9 → 120 pairs, (0,1) through (14,15), in lexicographic order. Scan takes 120 cycles with pair_ready=1.
- Reset mid-SCAN: assert reset while pair_valid=1 on (0,2) → next cycle pair_valid=0, busy=0, cfg_ready=1. A new cfg plus the basic-scan weights reproduces the basic-scan result.
